// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage.
// Passes ALU results through to write-back with one cycle of latency and
// runs byte/half/word loads and stores over a registered req/ack handshake,
// holding the upstream pipeline while an access is outstanding.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses on misalign_o/misalign_addr_o instead of aligning them down.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access outstanding; ALU results pass through, new ops issue
// S_WAIT | request on dmem; waiting for dmem_ack_i, upstream held
module mem_access_stage #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic                  ex_w_enable_i,
    input  logic [REG_ADDR_W-1:0] ex_w_addr_i,
    input  logic [31:0]           ex_w_data_i,
    input  logic [3:0]            ex_memop_i,
    input  logic [31:0]           ex_store_data_i,
    output logic                  stall_req_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [31:0]           dmem_rdata_i,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalign_o,
    output logic [ADDR_W-1:0]     misalign_addr_o,
`endif
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [31:0]           w_data_o
);

    localparam logic [3:0] MOP_LB  = 4'h1;
    localparam logic [3:0] MOP_LH  = 4'h2;
    localparam logic [3:0] MOP_LW  = 4'h3;
    localparam logic [3:0] MOP_LBU = 4'h4;
    localparam logic [3:0] MOP_LHU = 4'h5;
    localparam logic [3:0] MOP_SB  = 4'h8;
    localparam logic [3:0] MOP_SH  = 4'h9;
    localparam logic [3:0] MOP_SW  = 4'hA;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]     ea;
    logic                  is_load, is_store, is_byte, is_half, is_word;
    logic                  misalign_c, mem_issue;
    logic [1:0]            lane;
    logic [3:0]            be_nx;
    logic [31:0]           wdata_nx;

    logic [REG_ADDR_W-1:0] rd_q;
    logic [3:0]            op_q;
    logic [1:0]            lane_q;
    logic                  ld_q;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           load_fmt;

    assign ea = ex_w_data_i[ADDR_W-1:0];

    // Decode the execute-stage memop and build the request fields.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (ex_memop_i)
            MOP_LB, MOP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            MOP_LH, MOP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            MOP_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
            MOP_SB:          begin is_store = 1'b1; is_byte = 1'b1; end
            MOP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
            MOP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase

        // Half ops ignore ea[0] and word ops ignore ea[1:0] when aligning down.
        lane     = 2'b00;
        be_nx    = 4'b1111;
        wdata_nx = ex_store_data_i;
        if (is_byte) begin
            lane     = ea[1:0];
            be_nx    = 4'b0001 << ea[1:0];
            wdata_nx = {4{ex_store_data_i[7:0]}};
        end else if (is_half) begin
            lane     = {ea[1], 1'b0};
            be_nx    = ea[1] ? 4'b1100 : 4'b0011;
            wdata_nx = {2{ex_store_data_i[15:0]}};
        end

`ifdef MEM_MISALIGN_TRAP_EN
        misalign_c = ex_valid_i && ((is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00)));
`else
        misalign_c = 1'b0;
`endif
        mem_issue = ex_valid_i && (is_load || is_store) && !misalign_c;
    end

    // Extract the addressed lane from the returned word and extend it.
    always_comb begin
        case (lane_q)
            2'd0:    rbyte = dmem_rdata_i[7:0];
            2'd1:    rbyte = dmem_rdata_i[15:8];
            2'd2:    rbyte = dmem_rdata_i[23:16];
            default: rbyte = dmem_rdata_i[31:24];
        endcase
        rhalf = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (op_q)
            MOP_LB:  load_fmt = {{24{rbyte[7]}}, rbyte};
            MOP_LBU: load_fmt = {24'h0, rbyte};
            MOP_LH:  load_fmt = {{16{rhalf[15]}}, rhalf};
            MOP_LHU: load_fmt = {16'h0, rhalf};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (mem_issue)  state_nx = S_WAIT;
            S_WAIT:  if (dmem_ack_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Stall is raised the cycle an op is accepted and released on the ack cycle.
    always_comb begin
        stall_req_o = 1'b0;
        case (state)
            S_IDLE:  stall_req_o = mem_issue;
            S_WAIT:  stall_req_o = !dmem_ack_i;
            default: stall_req_o = 1'b0;
        endcase
    end

    // Registered request, write-back and bookkeeping fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_be_o       <= 4'h0;
            dmem_wdata_o    <= 32'h0;
            w_enable_o      <= 1'b0;
            w_addr_o        <= '0;
            w_data_o        <= 32'h0;
            rd_q            <= '0;
            op_q            <= 4'h0;
            lane_q          <= 2'b00;
            ld_q            <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!ex_valid_i) begin
                        w_enable_o <= 1'b0;
                    end else if (mem_issue) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_store;
                        dmem_addr_o  <= {ea[ADDR_W-1:2], 2'b00};
                        dmem_be_o    <= be_nx;
                        dmem_wdata_o <= wdata_nx;
                        rd_q         <= ex_w_addr_i;
                        op_q         <= ex_memop_i;
                        lane_q       <= lane;
                        ld_q         <= is_load;
                        w_enable_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    end else if (misalign_c) begin
                        misalign_o      <= 1'b1;
                        misalign_addr_o <= ea;
                        w_enable_o      <= 1'b0;
`endif
                    end else begin
                        w_enable_o <= ex_w_enable_i;
                        w_addr_o   <= ex_w_addr_i;
                        w_data_o   <= ex_w_data_i;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        w_enable_o <= ld_q;
                        if (ld_q) begin
                            w_addr_o <= rd_q;
                            w_data_o <= load_fmt;
                        end
                    end else begin
                        w_enable_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; inputs change 1ns after rising
// edges, outputs are sampled on falling edges.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_w_enable_i;
    logic [4:0]  ex_w_addr_i;
    logic [31:0] ex_w_data_i, ex_store_data_i;
    logic [3:0]  ex_memop_i;
    logic        stall_req_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_w_enable_i   (ex_w_enable_i),
        .ex_w_addr_i     (ex_w_addr_i),
        .ex_w_data_i     (ex_w_data_i),
        .ex_memop_i      (ex_memop_i),
        .ex_store_data_i (ex_store_data_i),
        .stall_req_o     (stall_req_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o),
`endif
        .w_enable_o      (w_enable_o),
        .w_addr_o        (w_addr_o),
        .w_data_o        (w_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic [3:0] op, input logic [31:0] sd);
        ex_valid_i      = v;
        ex_w_enable_i   = we;
        ex_w_addr_i     = rd;
        ex_w_data_i     = d;
        ex_memop_i      = op;
        ex_store_data_i = sd;
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        step();
        dmem_ack_i = 1'b1;
        step();
        @(negedge clk);
        chk("rst_req",    {31'h0, dmem_req_o},  32'h0);
        chk("rst_stall",  {31'h0, stall_req_o}, 32'h0);
        chk("rst_wen",    {31'h0, w_enable_o},  32'h0);
        chk("rst_wdata",  w_data_o,             32'h0);
        chk("rst_be",     {28'h0, dmem_be_o},   32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored_req", {31'h0, dmem_req_o}, 32'h0);
        dmem_ack_i = 1'b0;

        // ALU pass-through
        step();
        drive(1'b1, 1'b1, 5'd5, 32'h1234, 4'h0, 32'h0);
        @(negedge clk);
        chk("alu_stall", {31'h0, stall_req_o}, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("alu_wen",   {31'h0, w_enable_o}, 32'h1);
        chk("alu_waddr", {27'h0, w_addr_o},   32'd5);
        chk("alu_wdata", w_data_o,            32'h1234);
        chk("alu_req",   {31'h0, dmem_req_o}, 32'h0);
        step();
        @(negedge clk);
        chk("bubble_wen", {31'h0, w_enable_o}, 32'h0);

        // LB ea 0x103, three WAIT cycles without ack
        step();
        drive(1'b1, 1'b1, 5'd7, 32'h103, 4'h1, 32'h0);
        stall_cnt = 0;
        @(negedge clk);
        chk("lb_stall_T", {31'h0, stall_req_o}, 32'h1);
        if (stall_req_o) stall_cnt++;
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_wait_req", {31'h0, dmem_req_o}, 32'h1);
            chk("lb_wait_wen", {31'h0, w_enable_o}, 32'h0);
            if (stall_req_o) stall_cnt++;
            if (i == 0) begin
                chk("lb_be",   {28'h0, dmem_be_o}, 32'h8);
                chk("lb_addr", dmem_addr_o,        32'h100);
                chk("lb_we",   {31'h0, dmem_we_o}, 32'h0);
            end
            step();
        end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h80FF_FF00;
        @(negedge clk);
        chk("lb_ack_stall", {31'h0, stall_req_o}, 32'h0);
        chk("lb_stall_cycles", stall_cnt, 32'd4);
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("lb_wen",   {31'h0, w_enable_o}, 32'h1);
        chk("lb_waddr", {27'h0, w_addr_o},   32'd7);
        chk("lb_wdata", w_data_o,            32'hFFFF_FF80);
        chk("lb_req_drop", {31'h0, dmem_req_o}, 32'h0);

        // LHU ea 0x202, ack at T+1
        step();
        drive(1'b1, 1'b1, 5'd9, 32'h202, 4'h5, 32'h0);
        @(negedge clk);
        chk("lhu_stall_T", {31'h0, stall_req_o}, 32'h1);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h8001_1234;
        @(negedge clk);
        chk("lhu_be",    {28'h0, dmem_be_o}, 32'hC);
        chk("lhu_addr",  dmem_addr_o,        32'h200);
        chk("lhu_stall_ack", {31'h0, stall_req_o}, 32'h0);
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("lhu_wen",   {31'h0, w_enable_o}, 32'h1);
        chk("lhu_waddr", {27'h0, w_addr_o},   32'd9);
        chk("lhu_wdata", w_data_o,            32'h0000_8001);

        // LH ea 0x106 (sign-extend upper half)
        step();
        drive(1'b1, 1'b1, 5'd3, 32'h106, 4'h2, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h8765_4321;
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("lh_wdata", w_data_o, 32'hFFFF_8765);

        // SB ea 0x301, data 0xAB
        step();
        drive(1'b1, 1'b1, 5'd4, 32'h301, 4'h8, 32'h0000_00AB);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("sb_we",    {31'h0, dmem_we_o}, 32'h1);
        chk("sb_be",    {28'h0, dmem_be_o}, 32'h2);
        chk("sb_wdata", dmem_wdata_o,       32'hABAB_ABAB);
        chk("sb_addr",  dmem_addr_o,        32'h300);
        step();
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("sb_wen", {31'h0, w_enable_o}, 32'h0);
        chk("sb_req", {31'h0, dmem_req_o}, 32'h0);

        // SH ea 0x12, data 0x5A5A_C3D4
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h12, 4'h9, 32'h5A5A_C3D4);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("sh_be",    {28'h0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o,       32'hC3D4_C3D4);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;

        // Reset while waiting; the following ack must be ignored
        step();
        drive(1'b1, 1'b1, 5'd6, 32'h500, 4'h3, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstw_req_before", {31'h0, dmem_req_o}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstw_req",   {31'h0, dmem_req_o},  32'h0);
        chk("rstw_stall", {31'h0, stall_req_o}, 32'h0);
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("rstw_wen", {31'h0, w_enable_o}, 32'h0);
        chk("rstw_req_after", {31'h0, dmem_req_o}, 32'h0);

        // Misaligned LW ea 0x402
        step();
        drive(1'b1, 1'b1, 5'd8, 32'h402, 4'h3, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        chk("mis_stall", {31'h0, stall_req_o}, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("mis_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("mis_flag",  {31'h0, misalign_o}, 32'h1);
        chk("mis_addr",  misalign_addr_o,     32'h402);
        chk("mis_wen",   {31'h0, w_enable_o}, 32'h0);
        step();
        @(negedge clk);
        chk("mis_pulse_end", {31'h0, misalign_o}, 32'h0);
`else
        @(negedge clk);
        chk("lwmis_stall", {31'h0, stall_req_o}, 32'h1);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h1122_3344;
        @(negedge clk);
        chk("lwmis_be",   {28'h0, dmem_be_o}, 32'hF);
        chk("lwmis_addr", dmem_addr_o,        32'h400);
        step();
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("lwmis_wen",   {31'h0, w_enable_o}, 32'h1);
        chk("lwmis_wdata", w_data_o,            32'h1122_3344);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
